// File: rtl/filt_peak_detect_16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_peak_detect_16_pkg : FSM encodings and defaults for the peak detector |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package filt_peak_detect_16_pkg;

  typedef enum logic [1:0] {
    FPD_IDLE  = 2'd0,
    FPD_ARMED = 2'd1,
    FPD_WAIT  = 2'd2
  } fpd_state_e;

  localparam int unsigned FPD_DATA_WIDTH = 16;
  localparam int unsigned FPD_TS_WIDTH   = 16;
  localparam int unsigned FPD_MAX_SPAN   = 64;

  // Span counter only has to reach MAX_SPAN-1.
  function automatic int unsigned fpd_span_width(input int unsigned max_span);
    return (max_span <= 2) ? 1 : $clog2(max_span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/filt_peak_detect_16_evt_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_peak_detect_16_evt_reg : single-entry valid/ready event register with |
// | drop detection and sticky overflow flag.                     Rev 1.0       |
// +----------------------------------------------------------------------------+
module filt_peak_detect_16_evt_reg #(
  parameter int PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [PAYLOAD_W-1:0] load_data,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 out_ready,
  output logic                 ovf
);

  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A slot frees up in the same cycle it is accepted, so back-to-back loads are lossless.
    if (load_valid) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        data_d  = load_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: rtl/filt_peak_detect_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_peak_detect_16 : hysteresis pulse finder reporting peak value, peak   |
// | timestamp and timeout flag per pulse.                        Rev 1.0       |
// +----------------------------------------------------------------------------+
module filt_peak_detect_16
  import filt_peak_detect_16_pkg::*;
#(
  parameter int DATA_WIDTH = FPD_DATA_WIDTH,
  parameter int TS_WIDTH   = FPD_TS_WIDTH,
  parameter int MAX_SPAN   = FPD_MAX_SPAN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] thresh_hi,
  input  logic [DATA_WIDTH-1:0] thresh_lo,
  output logic [DATA_WIDTH-1:0] peak_val,
  output logic [TS_WIDTH-1:0]   peak_ts,
  output logic                  peak_trunc,
  output logic                  peak_valid,
  input  logic                  peak_ready,
  output logic                  busy,
  output logic                  ovf
);

  localparam int SPAN_W = fpd_span_width(MAX_SPAN);
  localparam logic [SPAN_W-1:0] SPAN_LAST = SPAN_W'(MAX_SPAN - 1);
  localparam int EVT_W = DATA_WIDTH + TS_WIDTH + 1;

  fpd_state_e                   state_q, state_d;
  logic [TS_WIDTH-1:0]          ts_q, ts_d;
  logic [TS_WIDTH-1:0]          max_ts_q, max_ts_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [SPAN_W-1:0]            span_q, span_d;
  logic                         busy_q, busy_d;

  logic signed [DATA_WIDTH-1:0] s, hi, lo;
  logic                         emit, emit_trunc;
  logic signed [DATA_WIDTH-1:0] emit_val;
  logic [TS_WIDTH-1:0]          emit_ts;
  logic [EVT_W-1:0]             evt_data;

  assign s  = $signed(data_in);
  assign hi = $signed(thresh_hi);
  assign lo = $signed(thresh_lo);

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    max_d      = max_q;
    max_ts_d   = max_ts_q;
    span_d     = span_q;
    emit       = 1'b0;
    emit_trunc = 1'b0;
    emit_val   = max_q;
    emit_ts    = max_ts_q;
    if (data_valid) begin
      ts_d = ts_q + TS_WIDTH'(1);
      unique case (state_q)
        FPD_IDLE: begin
          if (s >= hi) begin
            state_d  = FPD_ARMED;
            max_d    = s;
            max_ts_d = ts_q;
            span_d   = SPAN_W'(1);
          end
        end
        FPD_ARMED: begin
          // Release wins over timeout, and the closing sample never counts toward the peak.
          if (s < lo) begin
            emit    = 1'b1;
            state_d = FPD_IDLE;
          end else begin
            if (s > max_q) begin
              max_d    = s;
              max_ts_d = ts_q;
            end
            if (span_q == SPAN_LAST) begin
              emit       = 1'b1;
              emit_trunc = 1'b1;
              emit_val   = max_d;
              emit_ts    = max_ts_d;
              state_d    = FPD_WAIT;
            end else begin
              span_d = span_q + SPAN_W'(1);
            end
          end
        end
        FPD_WAIT: begin
          if (s < lo) begin
            state_d = FPD_IDLE;
          end
        end
        default: state_d = FPD_IDLE;
      endcase
    end
    busy_d = (state_d != FPD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FPD_IDLE;
      ts_q     <= '0;
      max_q    <= '0;
      max_ts_q <= '0;
      span_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      max_q    <= max_d;
      max_ts_q <= max_ts_d;
      span_q   <= span_d;
      busy_q   <= busy_d;
    end
  end

  filt_peak_detect_16_evt_reg #(
    .PAYLOAD_W (EVT_W)
  ) u_evt_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (emit),
    .load_data  ({emit_trunc, emit_ts, emit_val}),
    .out_valid  (peak_valid),
    .out_data   (evt_data),
    .out_ready  (peak_ready),
    .ovf        (ovf)
  );

  assign {peak_trunc, peak_ts, peak_val} = evt_data;
  assign busy = busy_q;

endmodule
`default_nettype wire
